data_bus_responder: RTL and testbench
=====================================

Name: data_bus_responder

Overview:
- Responder end of the core's data-memory port: decodes core loads and stores into a synchronous data RAM region and a small MMIO register block.
- The MMIO block holds a 32-bit timer, a compare register, control and status registers, and an LED register.
- Inserts a one-cycle stall for RAM reads to cover the synchronous RAM read latency.
- Drives the core's interrupter input from a timer-match event.

Parameters:
- RAM_ADDR_W, 10: word-address width of data RAM; ram_addr = mem_addr[RAM_ADDR_W+1:2].
- MMIO_BASE, 32'hFFFF_FF00: MMIO page base; decode on mem_addr[31:8] == MMIO_BASE[31:8].
- LED_W, 16: width of LED register/output.

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- mem_ren  in  1  core read request
- mem_wen  in  1  core write request
- mem_addr  in  32  core byte address, word-aligned (bits [1:0] ignored)
- mem_wdata  in  32  store data from core
- mem_rdata  out  32  load data to core
- mem_stall  out  1  core holds request and pipeline while high
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_ADDR_W  RAM word address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, valid one cycle after address
- interrupter  out  1  interrupt request to core, level
- led  out  LED_W  LED register contents

Behaviour:
- Reset values: all registers 0, FSM = IDLE, mem_stall=0, interrupter=0, led=0, mem_rdata=0, ram_we=0.
- Decode: MMIO if mem_addr[31:8] == MMIO_BASE[31:8], else RAM.
- ram_addr = mem_addr[RAM_ADDR_W+1:2] and ram_din = mem_wdata at all times (combinational).
- mem_wen and mem_ren together: treated as a write, no stall.
- RAM write: ram_we = mem_wen & RAM region, combinational; zero wait; no stall.
- RAM read, FSM IDLE -> RD_WAIT -> IDLE:
  - Cycle 0, IDLE with mem_ren & ~mem_wen & RAM region: mem_stall=1; next state RD_WAIT.
  - Cycle 1, RD_WAIT: mem_stall=0; mem_rdata=ram_dout; next state IDLE.
  - Core holds request stable while stalled. Exactly 1 stall cycle per RAM read.
  - Back-to-back reads each stall once.
- MMIO read: zero wait, combinational mux, no stall. Offsets:
  - 0x00 CNT
  - 0x04 CMP
  - 0x08 CTRL {29'b0, auto_reload, irq_en, tmr_en}
  - 0x0C STATUS {31'b0, pending}
  - 0x10 LED, zero-extended
  - Any other offset reads 0.
- MMIO write takes effect at the clock edge:
  - CNT, CMP, CTRL[2:0], LED[LED_W-1:0] load from mem_wdata.
  - STATUS: writing bit0=1 clears pending.
  - Writes to unmapped offsets are ignored.
- mem_rdata when no read is active: 0.
- Timer, evaluated each edge when tmr_en=1:
  - If CNT == CMP: pending <= 1; CNT <= auto_reload ? 0 : CNT+1.
  - Otherwise CNT <= CNT+1. Wraps 0xFFFF_FFFF -> 0.
  - tmr_en=0: CNT holds; no new match.
- Simultaneous events:
  - CPU write to CNT in the same cycle as a match: the write value wins for CNT, and pending is still set.
  - STATUS clear in the same cycle as a new match: set wins; pending stays 1.
- interrupter = pending & irq_en, combinational from registers. It stays high until cleared or irq_en=0.
- Reset mid-RD_WAIT: FSM to IDLE, mem_stall=0, mem_rdata=0. Registers return to reset values.

Test Plan:
- RAM store/load: write 0x1234_5678 to 0x0000_0010 -> ram_we=1, ram_addr=4 in that cycle, no stall. Read the same address -> mem_stall=1 for exactly 1 cycle, then mem_rdata=0x1234_5678.
- Back-to-back RAM reads at 0x0, 0x4, then ren+wen together at 0x8 -> two single-cycle stalls, then write with no stall.
- Timer with auto-reload:
  - Setup: CMP=5, CTRL=0b111.
  - Required: CNT counts 0..5, then 0. pending=1 and interrupter=1 from the cycle after CNT==5.
  - Write STATUS=1 -> interrupter=0 the next cycle, until the next match.
- Timer wrap: CNT=0xFFFF_FFFE, CMP=0x10, CTRL=0b001 -> CNT goes FFFF_FFFF, 0000_0000, ..., and pending is set at 0x10. CTRL irq_en=0 -> interrupter stays 0 while pending=1.
- Simultaneous events: STATUS clear in the match cycle -> pending stays 1. CNT write of 0x100 in the match cycle -> CNT=0x100 and pending=1.
- MMIO and reset:
  - Write LED=0xA5A5 -> led=0xA5A5; read 0xFFFF_FF10 = 0x0000_A5A5 with no stall. Read offset 0x20 = 0.
  - Assert rst during RD_WAIT -> next cycle mem_stall=0, led=0, CNT=0, FSM IDLE.

Source files
------------

// File: rtl/data_bus_responder.sv
// Data-memory port responder: decodes core loads/stores into a synchronous RAM
// region and an MMIO page holding a timer/compare, control, status and LED register.
module data_bus_responder #(
  parameter int unsigned RAM_ADDR_W = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00,
  parameter int unsigned LED_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_stall,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout,
  output logic                  interrupter,
  output logic [LED_W-1:0]      led
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RD_WAIT = 1'b1;

  localparam logic [5:0] OFF_CNT    = 6'h00;
  localparam logic [5:0] OFF_CMP    = 6'h01;
  localparam logic [5:0] OFF_CTRL   = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;
  localparam logic [5:0] OFF_LED    = 6'h04;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [31:0]      r_cnt;
  logic [31:0]      r_cmp;
  logic             r_tmr_en;
  logic             r_irq_en;
  logic             r_auto_reload;
  logic             r_pending;
  logic [LED_W-1:0] r_led;

  logic       w_is_mmio;
  logic [5:0] w_off;
  logic       w_rd;
  logic       w_ram_rd;
  logic       w_mmio_wr;
  logic       w_match;
  logic       w_stall;
  logic       w_unused;

  assign w_is_mmio = (mem_addr[31:8] == MMIO_BASE[31:8]);
  assign w_off     = mem_addr[7:2];
  // A simultaneous read+write request is handled purely as a write.
  assign w_rd      = mem_ren & ~mem_wen;
  assign w_ram_rd  = w_rd & ~w_is_mmio;
  assign w_mmio_wr = mem_wen & w_is_mmio;
  assign w_match   = r_tmr_en & (r_cnt == r_cmp);
  assign w_unused  = &{1'b0, mem_addr[1:0]};

  assign ram_addr    = mem_addr[RAM_ADDR_W+1:2];
  assign ram_din     = mem_wdata;
  assign ram_we      = mem_wen & ~w_is_mmio;
  assign mem_stall   = w_stall;
  assign interrupter = r_pending & r_irq_en;
  assign led         = r_led;

  // Read-latency FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // One stall cycle while the synchronous RAM produces read data.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ram_rd) begin
          w_stall     = 1'b1;
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Load data: RAM data in the wait cycle, MMIO mux for page reads, else 0.
  always_comb begin
    mem_rdata = 32'h0;
    if (r_state == S_RD_WAIT) begin
      mem_rdata = ram_dout;
    end else if (w_rd && w_is_mmio) begin
      case (w_off)
        OFF_CNT:    mem_rdata = r_cnt;
        OFF_CMP:    mem_rdata = r_cmp;
        OFF_CTRL:   mem_rdata = {29'h0, r_auto_reload, r_irq_en, r_tmr_en};
        OFF_STATUS: mem_rdata = {31'h0, r_pending};
        OFF_LED:    mem_rdata = 32'(r_led);
        default:    mem_rdata = 32'h0;
      endcase
    end
  end

  // Timer counter; a CPU write to CNT overrides the count update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 32'h0;
    end else if (w_mmio_wr && (w_off == OFF_CNT)) begin
      r_cnt <= mem_wdata;
    end else if (r_tmr_en) begin
      r_cnt <= (w_match && r_auto_reload) ? 32'h0 : r_cnt + 32'd1;
    end
  end

  // Pending flag: a new match takes priority over a software clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_match) begin
      r_pending <= 1'b1;
    end else if (w_mmio_wr && (w_off == OFF_STATUS) && mem_wdata[0]) begin
      r_pending <= 1'b0;
    end
  end

  // Plain software-loaded MMIO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp         <= 32'h0;
      r_tmr_en      <= 1'b0;
      r_irq_en      <= 1'b0;
      r_auto_reload <= 1'b0;
      r_led         <= '0;
    end else if (w_mmio_wr) begin
      case (w_off)
        OFF_CMP:  r_cmp <= mem_wdata;
        OFF_CTRL: begin
          r_tmr_en      <= mem_wdata[0];
          r_irq_en      <= mem_wdata[1];
          r_auto_reload <= mem_wdata[2];
        end
        OFF_LED:  r_led <= mem_wdata[LED_W-1:0];
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: synchronous RAM stand-in, a register-level model
// checked every cycle, and directed sequences with literal expectations.
module tb_data_bus_responder;

  localparam logic [31:0] A_CNT  = 32'hFFFF_FF00;
  localparam logic [31:0] A_CMP  = 32'hFFFF_FF04;
  localparam logic [31:0] A_CTRL = 32'hFFFF_FF08;
  localparam logic [31:0] A_STAT = 32'hFFFF_FF0C;
  localparam logic [31:0] A_LED  = 32'hFFFF_FF10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 32'h0;
  logic        interrupter;
  logic [15:0] led;

  int checks = 0;
  int passes = 0;
  logic run = 1'b0;

  data_bus_responder dut (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .interrupter(interrupter), .led(led)
  );

  always #5 clk = ~clk;

  // Synchronous RAM seen by the DUT (read-before-write).
  logic [31:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  // Model state: expected RAM contents and MMIO registers.
  logic [31:0] exp_mem [1024];
  logic [31:0] m_cnt = 32'h0;
  logic [31:0] m_cmp = 32'h0;
  logic [2:0]  m_ctrl = 3'h0;
  logic        m_pend = 1'b0;
  logic [15:0] m_led = 16'h0;
  logic        m_rdwait = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic is_mmio(input logic [31:0] a);
    return a[31:8] == 24'hFFFFFF;
  endfunction

  function automatic logic mmio_wr(input logic [5:0] off);
    return mem_wen && is_mmio(mem_addr) && mem_addr[7:2] == off;
  endfunction

  function automatic logic [31:0] mmio_val(input logic [5:0] off);
    case (off)
      6'd0:    return m_cnt;
      6'd1:    return m_cmp;
      6'd2:    return {29'h0, m_ctrl};
      6'd3:    return {31'h0, m_pend};
      6'd4:    return {16'h0, m_led};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_stall();
    return mem_ren && !mem_wen && !is_mmio(mem_addr) && !m_rdwait;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (m_rdwait) return exp_mem[mem_addr[11:2]];
    if (mem_ren && !mem_wen && is_mmio(mem_addr)) return mmio_val(mem_addr[7:2]);
    return 32'h0;
  endfunction

  function automatic logic hit();
    return m_ctrl[0] && (m_cnt == m_cmp);
  endfunction

  function automatic logic [31:0] cnt_after();
    if (mmio_wr(6'd0)) return mem_wdata;
    if (!m_ctrl[0]) return m_cnt;
    if (hit() && m_ctrl[2]) return 32'h0;
    return m_cnt + 32'd1;
  endfunction

  function automatic logic pend_after();
    if (hit()) return 1'b1;
    if (mmio_wr(6'd3) && mem_wdata[0]) return 1'b0;
    return m_pend;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 32'h0; m_cmp <= 32'h0; m_ctrl <= 3'h0;
      m_pend <= 1'b0; m_led <= 16'h0; m_rdwait <= 1'b0;
    end else begin
      m_rdwait <= exp_stall();
      if (mem_wen && !is_mmio(mem_addr)) exp_mem[mem_addr[11:2]] <= mem_wdata;
      m_cnt  <= cnt_after();
      m_pend <= pend_after();
      if (mmio_wr(6'd1)) m_cmp  <= mem_wdata;
      if (mmio_wr(6'd2)) m_ctrl <= mem_wdata[2:0];
      if (mmio_wr(6'd4)) m_led  <= mem_wdata[15:0];
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("mem_stall", {31'h0, mem_stall}, {31'h0, exp_stall()});
      chk("mem_rdata", mem_rdata, exp_rdata());
      chk("ram_we", {31'h0, ram_we}, {31'h0, mem_wen && !is_mmio(mem_addr)});
      chk("ram_addr", {22'h0, ram_addr}, {22'h0, mem_addr[11:2]});
      chk("ram_din", ram_din, mem_wdata);
      chk("interrupter", {31'h0, interrupter}, {31'h0, m_pend && m_ctrl[1]});
      chk("led", {16'h0, led}, {16'h0, m_led});
    end
  end

  task automatic cyc(input logic rs, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = rs; mem_ren = r; mem_wen = w; mem_addr = a; mem_wdata = d;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    run = 1'b1;
    do_reset();
    chk("reset_stall", {31'h0, mem_stall}, 32'h0);
    chk("reset_irq", {31'h0, interrupter}, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_ram_we", {31'h0, ram_we}, 32'h0);

    // RAM store then load
    wr(32'h0000_0010, 32'h1234_5678);
    chk("st_we", {31'h0, ram_we}, 32'h1);
    chk("st_addr", {22'h0, ram_addr}, 32'h4);
    chk("st_stall", {31'h0, mem_stall}, 32'h0);
    rd(32'h0000_0010);
    chk("ld_stall0", {31'h0, mem_stall}, 32'h1);
    rd(32'h0000_0010);
    chk("ld_stall1", {31'h0, mem_stall}, 32'h0);
    chk("ld_data", mem_rdata, 32'h1234_5678);

    // Back-to-back reads, then read+write as a write
    wr(32'h0, 32'h1111_1111);
    wr(32'h4, 32'h2222_2222);
    rd(32'h0); chk("b2b_s0", {31'h0, mem_stall}, 32'h1);
    rd(32'h0); chk("b2b_d0", mem_rdata, 32'h1111_1111);
    rd(32'h4); chk("b2b_s1", {31'h0, mem_stall}, 32'h1);
    rd(32'h4); chk("b2b_d1", mem_rdata, 32'h2222_2222);
    cyc(1'b0, 1'b1, 1'b1, 32'h8, 32'h3333_3333);
    chk("rw_stall", {31'h0, mem_stall}, 32'h0);
    chk("rw_we", {31'h0, ram_we}, 32'h1);
    rd(32'h8); rd(32'h8); chk("rw_data", mem_rdata, 32'h3333_3333);

    // Timer auto-reload
    do_reset();
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 6; i++) begin
      rd(A_CNT);
      chk("ar_cnt", mem_rdata, 32'(i));
      chk("ar_irq_lo", {31'h0, interrupter}, 32'h0);
    end
    rd(A_CNT);
    chk("ar_reload", mem_rdata, 32'h0);
    chk("ar_irq_hi", {31'h0, interrupter}, 32'h1);
    wr(A_STAT, 32'h1);
    chk("ar_irq_still", {31'h0, interrupter}, 32'h1);
    rd(A_STAT);
    chk("ar_cleared", mem_rdata, 32'h0);
    chk("ar_irq_clr", {31'h0, interrupter}, 32'h0);

    // Timer wrap with irq disabled
    do_reset();
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CMP, 32'h10);
    wr(A_CTRL, 32'h1);
    rd(A_CNT); chk("wr_fffe", mem_rdata, 32'hFFFF_FFFE);
    rd(A_CNT); chk("wr_ffff", mem_rdata, 32'hFFFF_FFFF);
    rd(A_CNT); chk("wr_zero", mem_rdata, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      rd(A_STAT);
      chk("wr_nopend", mem_rdata, 32'h0);
    end
    rd(A_STAT);
    chk("wr_pend", mem_rdata, 32'h1);
    chk("wr_irq_masked", {31'h0, interrupter}, 32'h0);
    wr(A_CTRL, 32'h3);
    idle();
    chk("wr_irq_unmask", {31'h0, interrupter}, 32'h1);

    // STATUS clear in the match cycle
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h3);
    idle(); idle(); idle();
    wr(A_STAT, 32'h1);
    rd(A_STAT);
    chk("sim_clr_pend", mem_rdata, 32'h1);
    chk("sim_clr_irq", {31'h0, interrupter}, 32'h1);

    // CNT write in the match cycle
    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h1);
    idle(); idle();
    wr(A_CNT, 32'h100);
    rd(A_CNT);  chk("sim_cnt", mem_rdata, 32'h100);
    rd(A_STAT); chk("sim_cnt_pend", mem_rdata, 32'h1);

    // LED, unmapped offset, reset during read wait
    do_reset();
    wr(A_LED, 32'hFFFF_A5A5);
    rd(A_LED);
    chk("led_out", {16'h0, led}, 32'hA5A5);
    chk("led_rd", mem_rdata, 32'h0000_A5A5);
    chk("led_nostall", {31'h0, mem_stall}, 32'h0);
    wr(32'hFFFF_FF20, 32'hDEAD_BEEF);
    rd(32'hFFFF_FF20); chk("unmapped", mem_rdata, 32'h0);
    wr(A_CTRL, 32'h1);
    rd(32'h40); chk("rst_pre_stall", {31'h0, mem_stall}, 32'h1);
    cyc(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    rd(A_CNT);
    chk("rst_stall", {31'h0, mem_stall}, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_cnt", mem_rdata, 32'h0);
    rd(32'h40); chk("rst_idle", {31'h0, mem_stall}, 32'h1);
    rd(32'h40); chk("rst_ld", mem_rdata, 32'h0);
    idle();

    run = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
